// File: rtl/md_pkg.sv
// md_pkg: shared opcode encoding, FSM states, default latencies and helpers for the multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_md_start(input md_op_t op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/multu/div/divu datapath producing the HI/LO result pair.
// Ports:
//   i_op      md opcode; only MULT/MULTU/DIV/DIVU produce a non-zero result
//   i_a, i_b  rs and rt operands
//   o_res_hi  product upper half, or remainder
//   o_res_lo  product lower half, or quotient
//   o_div0    divide op with a zero divisor
module md_arith
    import md_pkg::*;
(
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div0
);

    logic [63:0]        w_sprod;
    logic [63:0]        w_uprod;
    logic               w_b_zero;
    logic               w_b_neg1;
    logic [31:0]        w_ub;
    logic [31:0]        w_sb;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;

    assign w_sprod  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod  = {32'b0, i_a} * {32'b0, i_b};
    assign w_b_zero = (i_b == 32'b0);
    assign w_b_neg1 = (i_b == 32'hFFFF_FFFF);
    // Divisors are steered away from 0 (and from -1 for the signed path) so the
    // dividers never see an undefined case; those cases are resolved explicitly.
    assign w_ub     = w_b_zero ? 32'd1 : i_b;
    assign w_sb     = (w_b_zero | w_b_neg1) ? 32'd1 : i_b;
    // x / -1 is a wrapping negate with remainder 0 (covers 0x80000000 / -1).
    assign w_sq     = w_b_neg1 ? -$signed(i_a) : $signed(i_a) / $signed(w_sb);
    assign w_sr     = w_b_neg1 ? 32'sd0 : $signed(i_a) % $signed(w_sb);
    assign w_uq     = i_a / w_ub;
    assign w_ur     = i_a % w_ub;

    assign o_res_hi = (i_op == MD_MULT)  ? w_sprod[63:32] :
                      (i_op == MD_MULTU) ? w_uprod[63:32] :
                      (i_op == MD_DIV)   ? $unsigned(w_sr) :
                      (i_op == MD_DIVU)  ? w_ur : 32'b0;
    assign o_res_lo = (i_op == MD_MULT)  ? w_sprod[31:0] :
                      (i_op == MD_MULTU) ? w_uprod[31:0] :
                      (i_op == MD_DIV)   ? $unsigned(w_sq) :
                      (i_op == MD_DIVU)  ? w_uq : 32'b0;
    assign o_div0   = (i_op inside {MD_DIV, MD_DIVU}) & w_b_zero;

endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div scheduler that owns HI/LO and stalls dependent md-class instructions in D.
// Ports:
//   clk, reset          pipeline clock, asynchronous active-high reset
//   E_md_op             E-stage md opcode (MD_NONE for bubbles)
//   E_rs_val, E_rt_val  forwarded E-stage operands
//   D_md                D-stage instruction is md-class
//   md_stall            stall request to the D stage
//   busy                a mult/div is in flight
//   E_md_out            HI for MFHI, LO for MFLO, else 0
//   hi, lo              architectural HI/LO registers
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  md_op_t      E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_md,
    output logic        md_stall,
    output logic        busy,
    output logic [31:0] E_md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

    md_state_t   r_state;
    md_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_div0;
    logic        w_start_op;
    logic        w_start;
    logic        w_commit;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div0;

    md_arith u_arith (
        .i_op     (E_md_op),
        .i_a      (E_rs_val),
        .i_b      (E_rt_val),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo),
        .o_div0   (w_div0)
    );

    // An md op arriving while RUN is illegal and ignored, so only IDLE can start.
    assign w_start_op = is_md_start(E_md_op);
    assign w_start    = w_start_op & (r_state == ST_IDLE);
    assign w_commit   = (r_state == ST_RUN) & (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'b0;
            r_lo      <= 32'b0;
            r_pend_hi <= 32'b0;
            r_pend_lo <= 32'b0;
            r_div0    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_cnt     <= (E_md_op inside {MD_MULT, MD_MULTU}) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_div0    <= w_div0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - CW'(1);
                // A zero divisor burns the full latency but leaves HI/LO intact.
                if (w_commit && !r_div0) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                if (E_md_op == MD_MTHI) r_hi <= E_rs_val;
                if (E_md_op == MD_MTLO) r_lo <= E_rs_val;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) w_next = w_start ? ST_RUN : ST_IDLE;
        else                    w_next = w_commit ? ST_IDLE : ST_RUN;
    end

    // The start term covers the cycle the op sits in E, before busy rises.
    always_comb begin
        busy     = (r_state == ST_RUN);
        md_stall = D_md & (busy | w_start_op);
        E_md_out = (E_md_op == MD_MFHI) ? r_hi :
                   (E_md_op == MD_MFLO) ? r_lo : 32'b0;
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
